// File: rtl/axi_lite_word_slave.sv
// AXI4-Lite word responder backed by a resettable register memory; independent write and read FSMs.
// Optional byte-strobe merging is enabled by defining AXI_LITE_SLAVE_WSTRB_EN.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); commit once both are present
// W_RESP | write response pending on B
// R_IDLE | accepting AR
// R_DATA | read data/response pending on R
module axi_lite_word_slave #(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                          i_clk,
  input  logic                          i_arstn,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_awaddr,
  input  logic                          i_awvalid,
  output logic                          o_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                          i_wvalid,
  output logic                          o_wready,
  output logic [1:0]                    o_bresp,
  output logic                          o_bvalid,
  input  logic                          i_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_araddr,
  input  logic                          i_arvalid,
  output logic                          o_arready,
  output logic [AXI_DATA_WIDTH-1:0]     o_rdata,
  output logic [1:0]                    o_rresp,
  output logic                          o_rvalid,
  input  logic                          i_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e                  w_state_q;
  r_state_e                  r_state_q;
  logic                      aw_held_q, w_held_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      bvalid_q, rvalid_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] mem_d;

  logic                      aw_hs, w_hs, w_commit;
  logic [AXI_ADDR_WIDTH-1:0] w_addr, w_off, r_off;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic                      w_ok, r_ok;
  logic [IDX_W-1:0]          w_idx, r_idx;

  assign o_awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign o_wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign o_arready = (r_state_q == R_IDLE);
  assign o_bvalid  = bvalid_q;
  assign o_bresp   = bresp_q;
  assign o_rvalid  = rvalid_q;
  assign o_rresp   = rresp_q;
  assign o_rdata   = rdata_q;

  assign aw_hs    = i_awvalid && o_awready;
  assign w_hs     = i_wvalid && o_wready;
  assign w_commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // Whichever half was captured earlier comes from its holding register.
  assign w_addr = aw_held_q ? awaddr_q : i_awaddr;
  assign w_data = w_held_q ? wdata_q : i_wdata;
  assign w_off  = w_addr - BASE_ADDR;
  assign w_ok   = (w_addr >= BASE_ADDR) && (w_off[1:0] == 2'b00) &&
                  ((w_off >> 2) < AXI_ADDR_WIDTH'(MEM_DEPTH));
  assign w_idx  = w_off[2 +: IDX_W];

  assign r_off = i_araddr - BASE_ADDR;
  assign r_ok  = (i_araddr >= BASE_ADDR) && (r_off[1:0] == 2'b00) &&
                 ((r_off >> 2) < AXI_ADDR_WIDTH'(MEM_DEPTH));
  assign r_idx = r_off[2 +: IDX_W];

`ifdef AXI_LITE_SLAVE_WSTRB_EN
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  assign w_strb = w_held_q ? wstrb_q : i_wstrb;

  always_comb begin
    mem_d = w_data;
    for (int k = 0; k < AXI_DATA_WIDTH/8; k++) begin
      if (!w_strb[k]) mem_d[8*k +: 8] = mem_q[w_idx][8*k +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn)  wstrb_q <= '0;
    else if (w_hs) wstrb_q <= i_wstrb;
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^i_wstrb;

  always_comb begin
    mem_d = w_data;
  end
`endif

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (w_commit && w_ok) begin
      mem_q[w_idx] <= mem_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= i_awaddr;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= i_wdata;
          end
          if (w_commit) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Memory is sampled before this edge's write lands, so a colliding read sees the old word.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (i_arvalid) begin
            r_state_q <= R_DATA;
            rvalid_q  <= 1'b1;
            rresp_q   <= r_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q   <= r_ok ? mem_q[r_idx] : '0;
          end
        end
        R_DATA: begin
          if (i_rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_word_slave.sv
// Directed self-checking bench for axi_lite_word_slave (default parameters, BASE_ADDR = 0).
// Expected strobe-write result follows AXI_LITE_SLAVE_WSTRB_EN.
module tb_axi_lite_word_slave;

  logic        i_clk = 1'b0;
  logic        i_arstn = 1'b0;
  logic [63:0] i_awaddr = '0;
  logic        i_awvalid = 1'b0;
  logic        o_awready;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_wstrb = '0;
  logic        i_wvalid = 1'b0;
  logic        o_wready;
  logic [1:0]  o_bresp;
  logic        o_bvalid;
  logic        i_bready = 1'b0;
  logic [63:0] i_araddr = '0;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rvalid;
  logic        i_rready = 1'b0;

  int total = 0;
  int bad = 0;

  axi_lite_word_slave dut (
    .i_clk(i_clk), .i_arstn(i_arstn),
    .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled only at falling edges.
  task automatic wr(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er);
    @(negedge i_clk);
    chk("wr_awready", 64'(o_awready), 64'd1);
    chk("wr_wready", 64'(o_wready), 64'd1);
    chk("wr_bvalid_pre", 64'(o_bvalid), 64'd0);
    i_awaddr = a; i_awvalid = 1'b1; i_wdata = d; i_wstrb = s; i_wvalid = 1'b1;
    @(negedge i_clk);
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    chk("wr_bvalid", 64'(o_bvalid), 64'd1);
    chk("wr_bresp", 64'(o_bresp), 64'(er));
    chk("wr_awready_busy", 64'(o_awready), 64'd0);
    i_bready = 1'b1;
    @(negedge i_clk);
    i_bready = 1'b0;
    chk("wr_bdone", 64'(o_bvalid), 64'd0);
  endtask

  task automatic rd(input logic [63:0] a, input logic [31:0] ed, input logic [1:0] er);
    @(negedge i_clk);
    chk("rd_arready", 64'(o_arready), 64'd1);
    chk("rd_rvalid_pre", 64'(o_rvalid), 64'd0);
    i_araddr = a; i_arvalid = 1'b1;
    @(negedge i_clk);
    i_arvalid = 1'b0;
    chk("rd_rvalid", 64'(o_rvalid), 64'd1);
    chk("rd_rdata", 64'(o_rdata), 64'(ed));
    chk("rd_rresp", 64'(o_rresp), 64'(er));
    chk("rd_arready_busy", 64'(o_arready), 64'd0);
    i_rready = 1'b1;
    @(negedge i_clk);
    i_rready = 1'b0;
    chk("rd_rdone", 64'(o_rvalid), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_strb;
    logic [31:0] burst [4];
    burst[0] = 32'h11111111; burst[1] = 32'h22222222;
    burst[2] = 32'h33333333; burst[3] = 32'h44444444;

    // reset state
    #2;
    chk("rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rst_rvalid", 64'(o_rvalid), 64'd0);
    chk("rst_rdata", 64'(o_rdata), 64'd0);
    chk("rst_readies", {61'd0, o_awready, o_wready, o_arready}, 64'd7);
    @(negedge i_clk); @(negedge i_clk);
    i_arstn = 1'b1;

    // burst writes then reads
    for (int i = 0; i < 4; i++) wr(64'(4 * i), burst[i], 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) rd(64'(4 * i), burst[i], 2'b00);

    // W three cycles before AW at address 8
    @(negedge i_clk);
    i_wdata = 32'h0BADF00D; i_wstrb = 4'hF; i_wvalid = 1'b1;
    @(negedge i_clk);
    i_wvalid = 1'b0;
    chk("wfirst_wready_low", 64'(o_wready), 64'd0);
    chk("wfirst_awready", 64'(o_awready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("wfirst_no_bvalid", 64'(o_bvalid), 64'd0);
      chk("wfirst_wready_held", 64'(o_wready), 64'd0);
    end
    i_awaddr = 64'd8; i_awvalid = 1'b1;
    @(negedge i_clk);
    i_awvalid = 1'b0;
    chk("wfirst_bvalid", 64'(o_bvalid), 64'd1);
    chk("wfirst_bresp", 64'(o_bresp), 64'd0);
    i_bready = 1'b1;
    @(negedge i_clk);
    i_bready = 1'b0;
    chk("wfirst_wready_back", 64'(o_wready), 64'd1);
    rd(64'd8, 32'h0BADF00D, 2'b00);

    // out-of-range and misaligned
    wr(64'd256, 32'hFFFFFFFF, 4'hF, 2'b10);
    rd(64'd2, 32'h0, 2'b10);
    rd(64'd0, 32'h11111111, 2'b00);

    // stalled responses on both channels
    @(negedge i_clk);
    i_awaddr = 64'h20; i_wdata = 32'h55AA55AA; i_wstrb = 4'hF;
    i_awvalid = 1'b1; i_wvalid = 1'b1;
    i_araddr = 64'h4; i_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
      chk("stall_bvalid", 64'(o_bvalid), 64'd1);
      chk("stall_bresp", 64'(o_bresp), 64'd0);
      chk("stall_rvalid", 64'(o_rvalid), 64'd1);
      chk("stall_rdata", 64'(o_rdata), 64'h22222222);
      chk("stall_readies", {61'd0, o_awready, o_wready, o_arready}, 64'd0);
    end
    i_bready = 1'b1; i_rready = 1'b1;
    @(negedge i_clk);
    i_bready = 1'b0; i_rready = 1'b0;
    chk("stall_done_valids", {62'd0, o_bvalid, o_rvalid}, 64'd0);
    chk("stall_done_readies", {61'd0, o_awready, o_wready, o_arready}, 64'd7);
    rd(64'h20, 32'h55AA55AA, 2'b00);

    // same-cycle write and read of index 5
    @(negedge i_clk);
    i_awaddr = 64'h14; i_wdata = 32'hDEADBEEF; i_wstrb = 4'hF;
    i_awvalid = 1'b1; i_wvalid = 1'b1;
    i_araddr = 64'h14; i_arvalid = 1'b1;
    @(negedge i_clk);
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    chk("coll_bvalid", 64'(o_bvalid), 64'd1);
    chk("coll_rdata_old", 64'(o_rdata), 64'd0);
    i_bready = 1'b1; i_rready = 1'b1;
    @(negedge i_clk);
    i_bready = 1'b0; i_rready = 1'b0;
    rd(64'h14, 32'hDEADBEEF, 2'b00);

    // reset while a write response is pending
    @(negedge i_clk);
    i_awaddr = 64'h18; i_wdata = 32'h12345678; i_wstrb = 4'hF;
    i_awvalid = 1'b1; i_wvalid = 1'b1;
    @(negedge i_clk);
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    chk("pre_rst_bvalid", 64'(o_bvalid), 64'd1);
    i_arstn = 1'b0;
    #1;
    chk("async_rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("async_rst_readies", {61'd0, o_awready, o_wready, o_arready}, 64'd7);
    @(negedge i_clk); @(negedge i_clk);
    i_arstn = 1'b1;
    rd(64'h14, 32'h0, 2'b00);
    rd(64'h18, 32'h0, 2'b00);

    // partial strobe write to a zeroed word
`ifdef AXI_LITE_SLAVE_WSTRB_EN
    exp_strb = 32'h0000CCDD;
`else
    exp_strb = 32'hAABBCCDD;
`endif
    wr(64'h1C, 32'hAABBCCDD, 4'b0011, 2'b00);
    rd(64'h1C, exp_strb, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_word_slave.md
# axi_lite_word_slave

AXI4-Lite responder that terminates the sequential word transfers issued by the team's AXI4-Lite master and its address incrementer. Backed by a small word-addressed register memory. Independent write and read state machines; each transfer gets an OKAY or SLVERR response. Sits at the peripheral end of the interconnect as the target for burst-style word sequences that advance by 4 bytes per beat.

## Interface

- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 32, data width in bits (fixed 4-byte words).
- MEM_DEPTH, 64, number of words in the backing memory; power of two, at least 2.
- BASE_ADDR, 64'h0, byte address of word 0; 4-byte aligned.

Ports (clock and reset first):
- i_clk  input  1  clock; all state updates on the rising edge.
- i_arstn  input  1  asynchronous, active-low reset.
- i_awaddr  input  AXI_ADDR_WIDTH  write address.
- i_awvalid  input  1  write address valid.
- o_awready  output  1  write address ready.
- i_wdata  input  AXI_DATA_WIDTH  write data.
- i_wstrb  input  AXI_DATA_WIDTH/8  byte strobes.
- i_wvalid  input  1  write data valid.
- o_wready  output  1  write data ready.
- o_bresp  output  2  write response.
- o_bvalid  output  1  write response valid.
- i_bready  input  1  write response ready.
- i_araddr  input  AXI_ADDR_WIDTH  read address.
- i_arvalid  input  1  read address valid.
- o_arready  output  1  read address ready.
- o_rdata  output  AXI_DATA_WIDTH  read data.
- o_rresp  output  2  read response.
- o_rvalid  output  1  read data valid.
- i_rready  input  1  read data ready.

## Operation

- Address decode: offset = addr − BASE_ADDR, computed at AXI_ADDR_WIDTH bits. Valid iff addr ≥ BASE_ADDR, offset[1:0] = 0, and offset>>2 < MEM_DEPTH. Index = offset[2+:log2(MEM_DEPTH)].
- Valid access responds OKAY (2'b00). Invalid access responds SLVERR (2'b10), leaves memory unchanged, and returns o_rdata = 0.
- Write FSM states:
  - W_IDLE: o_awready = ~aw_held and o_wready = ~w_held. AW and W are captured independently, in either order or together.
  - When both are held, or both handshake in the same cycle, memory commits at that edge and the FSM enters W_RESP.
  - W_RESP: o_bvalid = 1 and o_bresp is stable. On i_bready the FSM returns to W_IDLE and clears aw_held and w_held.
- Read FSM states:
  - R_IDLE: o_arready = 1. On the AR handshake, memory is sampled, o_rdata and o_rresp are registered, and the FSM enters R_DATA.
  - R_DATA: o_rvalid = 1 with data and response stable. On i_rready the FSM returns to R_IDLE.
- Read and write FSMs are fully independent and may operate concurrently.
- Read and write to the same index committing in the same cycle: the read returns the old word.

## Timing

- Reset (i_arstn = 0) forces:
  - both FSMs to IDLE and aw_held = w_held = 0;
  - memory all zero;
  - o_bvalid = o_rvalid = 0, o_bresp = o_rresp = 0, o_rdata = 0;
  - o_awready = o_wready = o_arready = 1.
- Reset asserted mid-transfer abandons the transfer. A write is committed only if its commit edge occurred before reset.
- Write latency: commit edge at the end of cycle N, when the last of AW/W handshakes; o_bvalid is high in cycle N+1.
- Read latency: AR handshake in cycle N; o_rvalid and data are valid in cycle N+1.
- Throughput with i_bready / i_rready held high: one write per 2 cycles, one read per 2 cycles. No handshake occurs while a response is pending.
- o_bvalid and o_rvalid never drop before their handshake. Response payloads never change while valid.
- Readies are decodes of registered state only. There are no combinational paths from inputs to outputs.

## Configuration

- AXI_LITE_SLAVE_WSTRB_EN:
  - Defined: only bytes with i_wstrb[k] = 1 are written. A write with i_wstrb = 0 on a valid address responds OKAY and changes nothing.
  - Undefined: i_wstrb is ignored and every valid write replaces the full word.

## Test plan

- Burst of four writes to BASE_ADDR+0/4/8/12 with data 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, then four reads of the same addresses → all OKAY; reads return the same values in order; each o_bvalid / o_rvalid appears exactly one cycle after its handshake.
- W handshakes 3 cycles before AW at BASE_ADDR+8 → o_wready low after W capture; commit on the AW cycle; o_bvalid the next cycle.
- Write to BASE_ADDR + 4·MEM_DEPTH, and read of BASE_ADDR+2 → SLVERR for both; o_rdata = 0; memory unchanged, checked by readback.
- i_bready and i_rready held low for 5 cycles → o_bvalid / o_rvalid and their payloads stay stable; o_awready, o_wready and o_arready stay low; release completes the handshake and the FSMs return to IDLE.
- Same-cycle write of 32'hDEADBEEF and read of index 5, which holds 32'h0 → read returns 32'h0; a subsequent read returns 32'hDEADBEEF.
- i_arstn pulsed low while o_bvalid = 1; then, with AXI_LITE_SLAVE_WSTRB_EN defined, write i_wstrb = 4'b0011 with data 32'hAABBCCDD to a zeroed word:
  - during reset: o_bvalid = 0 immediately (asynchronously) and readies = 1;
  - after reset, readback returns 32'h0000CCDD;
  - with the macro undefined, readback returns 32'hAABBCCDD.
